// File: rtl/systolic_pkg.sv
// Shared types and helpers for the NxN output-stationary systolic multiplier.
package systolic_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StDrain,
    StOut
  } state_e;

  // Largest supported array; sizes the drain counter independently of N.
  localparam int unsigned MaxN        = 8;
  localparam int unsigned DrainCntMax = 2 * MaxN - 1;
  localparam int unsigned DrainCntW   = $clog2(DrainCntMax + 1);

  // Cycles needed after the last beat for it to reach PE(N-1,N-1).
  function automatic int unsigned drain_count(input int unsigned n);
    return 2 * n - 1;
  endfunction

  // LSB position of C[i][j] inside the flattened result bus.
  function automatic int unsigned res_slice(input int unsigned i, input int unsigned j,
                                            input int unsigned n, input int unsigned w);
    return (i * n + j) * w;
  endfunction

endpackage

// File: rtl/systolic_pe_mac.sv
// One processing element: registered MAC with pass-through operand/tag registers and a
// sticky overflow flag. Build option ACC_SAT_EN selects saturating instead of wrapping
// accumulation.
module systolic_pe_mac
  import systolic_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned ACC_W  = 2 * DW + 1,
  parameter int unsigned SIGNED = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [DW-1:0]    a_i,
  input  logic             a_vld_i,
  input  logic [DW-1:0]    b_i,
  input  logic             b_vld_i,
  output logic [DW-1:0]    a_o,
  output logic             a_vld_o,
  output logic [DW-1:0]    b_o,
  output logic             b_vld_o,
  output logic [ACC_W-1:0] acc_o,
  output logic             ovf_o
);

  localparam bit Sgn = (SIGNED != 0);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [2*DW-1:0]  a_ext, b_ext, prod;
  logic [ACC_W:0]   prod_ext, acc_ext, sum;
  logic             sum_ovf;

  // Operands extended to 2*DW so the low half of the product is exact in both modes.
  assign a_ext    = {{DW{Sgn & a_i[DW-1]}}, a_i};
  assign b_ext    = {{DW{Sgn & b_i[DW-1]}}, b_i};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACC_W + 1 - 2 * DW){Sgn & prod[2*DW-1]}}, prod};
  assign acc_ext  = {Sgn & acc_q[ACC_W-1], acc_q};
  assign sum      = acc_ext + prod_ext;
  // One extra bit holds the exact sum; it leaves the ACC_W range when the top bits disagree.
  assign sum_ovf  = Sgn ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];

`ifdef ACC_SAT_EN
  logic [ACC_W-1:0] sat_val;
  assign sat_val = !Sgn        ? {ACC_W{1'b1}} :
                   sum[ACC_W]  ? {1'b1, {(ACC_W - 1){1'b0}}} :
                                 {1'b0, {(ACC_W - 1){1'b1}}};
`endif

  // Next accumulator/flag: clear on start, accumulate only when both operand tags are set.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (a_vld_i && b_vld_i) begin
`ifdef ACC_SAT_EN
      // Once clamped the element stays at its limit until the next start.
      if (!ovf_q) begin
        if (sum_ovf) begin
          acc_d = sat_val;
          ovf_d = 1'b1;
        end else begin
          acc_d = sum[ACC_W-1:0];
        end
      end
`else
      acc_d = sum[ACC_W-1:0];
      if (sum_ovf) ovf_d = 1'b1;
`endif
    end
  end

  // Accumulator state plus operand/tag forwarding to the right and downward neighbours.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      a_o     <= '0;
      a_vld_o <= 1'b0;
      b_o     <= '0;
      b_vld_o <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      a_o     <= a_i;
      a_vld_o <= a_vld_i;
      b_o     <= b_i;
      b_vld_o <= b_vld_i;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/systolic_array_nxn.sv
// NxN output-stationary systolic multiplier, C = A[NxK] * B[KxN] over K handshaked beats.
// Holds the input skew registers, beat/drain counter and control FSM.
// Build option ACC_SAT_EN makes the PEs saturate on overflow instead of wrapping.
module systolic_array_nxn
  import systolic_pkg::*;
#(
  parameter int unsigned N      = 2,
  parameter int unsigned DW     = 32,
  parameter int unsigned ACC_W  = 2 * DW + 1,
  parameter int unsigned KW     = 8,
  parameter int unsigned SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [N*DW-1:0]      a_data,
  input  logic [N*DW-1:0]      b_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [N*N*ACC_W-1:0] res_data,
  output logic [N*N-1:0]       res_ovf,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CntW = (KW > DrainCntW) ? KW : DrainCntW;
  localparam logic [CntW-1:0] DrainCnt = CntW'(drain_count(N));
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            clr;
  logic            beat;

  // Horizontal (A) and vertical (B) operand/tag nets between PEs; index N is the far edge.
  logic [DW-1:0] a_h  [N][N+1];
  logic          av_h [N][N+1];
  logic [DW-1:0] b_v  [N+1][N];
  logic          bv_v [N+1][N];
  logic [N-1:0]  unused_edge;

  assign beat = a_valid & a_ready;

  // Control FSM: next state, counter and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    clr       = 1'b0;
    a_ready   = 1'b0;
    res_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          clr = 1'b1;
          if (k_len == '0) begin
            state_d = StOut;
          end else begin
            state_d = StFeed;
            cnt_d   = CntW'(k_len);
          end
        end
      end
      StFeed: begin
        a_ready = 1'b1;
        if (a_valid) begin
          if (cnt_q == CntOne) begin
            state_d = StDrain;
            cnt_d   = DrainCnt;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
      end
      StDrain: begin
        if (cnt_q == '0) state_d = StOut;
        else             cnt_d   = cnt_q - CntOne;
      end
      StOut: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state, counter and the registered done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;

  // Lane i of A and B gets i+1 register stages: the capture stage plus i cycles of skew.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DW-1:0] a_sk_q [i+1];
    logic [DW-1:0] b_sk_q [i+1];
    logic [i:0]    a_tg_q;
    logic [i:0]    b_tg_q;

    // Skew shift registers; tags mark which slots hold an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= i; s++) begin
          a_sk_q[s] <= '0;
          b_sk_q[s] <= '0;
        end
        a_tg_q <= '0;
        b_tg_q <= '0;
      end else begin
        if (beat) begin
          a_sk_q[0] <= a_data[i*DW +: DW];
          b_sk_q[0] <= b_data[i*DW +: DW];
        end
        a_tg_q[0] <= beat;
        b_tg_q[0] <= beat;
        for (int s = 1; s <= i; s++) begin
          a_sk_q[s] <= a_sk_q[s-1];
          b_sk_q[s] <= b_sk_q[s-1];
          a_tg_q[s] <= a_tg_q[s-1];
          b_tg_q[s] <= b_tg_q[s-1];
        end
      end
    end

    assign a_h[i][0]  = a_sk_q[i];
    assign av_h[i][0] = a_tg_q[i];
    assign b_v[0][i]  = b_sk_q[i];
    assign bv_v[0][i] = b_tg_q[i];

    // Operands leaving the right/bottom edge are not consumed.
    assign unused_edge[i] = ^{a_h[i][N], av_h[i][N], b_v[N][i], bv_v[N][i]};
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe_mac #(
        .DW    (DW),
        .ACC_W (ACC_W),
        .SIGNED(SIGNED)
      ) u_pe (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (clr),
        .a_i    (a_h[i][j]),
        .a_vld_i(av_h[i][j]),
        .b_i    (b_v[i][j]),
        .b_vld_i(bv_v[i][j]),
        .a_o    (a_h[i][j+1]),
        .a_vld_o(av_h[i][j+1]),
        .b_o    (b_v[i+1][j]),
        .b_vld_o(bv_v[i+1][j]),
        .acc_o  (res_data[res_slice(i, j, N, ACC_W) +: ACC_W]),
        .ovf_o  (res_ovf[i*N+j])
      );
    end
  end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Scoreboard bench for systolic_array_nxn (N=2, DW=8, ACC_W=20). An unsigned and a signed
// instance share the stimulus; `sel` picks which one is driven and observed.
module tb_systolic_array_nxn;

  localparam int N     = 2;
  localparam int DW    = 8;
  localparam int ACC_W = 20;
  localparam int KW    = 8;
`ifdef ACC_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  typedef struct {
    logic [N*N*ACC_W-1:0] c;
    logic [N*N-1:0]       ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic sel;
  logic start, a_valid, res_ready;
  logic [KW-1:0]   k_len;
  logic [N*DW-1:0] a_data, b_data;

  logic a_ready, res_valid, busy, done;
  logic [N*N*ACC_W-1:0] res_data;
  logic [N*N-1:0]       res_ovf;

  logic ar_u, rv_u, bz_u, dn_u, ar_s, rv_s, bz_s, dn_s;
  logic [N*N*ACC_W-1:0] rd_u, rd_s;
  logic [N*N-1:0]       ro_u, ro_s;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  int   a_m [N][32];
  int   b_m [32][N];

  always #5 clk = ~clk;

  systolic_array_nxn #(.N(N), .DW(DW), .ACC_W(ACC_W), .KW(KW), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .k_len(k_len),
    .a_valid(a_valid & ~sel), .a_ready(ar_u), .a_data(a_data), .b_data(b_data),
    .res_valid(rv_u), .res_ready(res_ready & ~sel), .res_data(rd_u), .res_ovf(ro_u),
    .busy(bz_u), .done(dn_u)
  );

  systolic_array_nxn #(.N(N), .DW(DW), .ACC_W(ACC_W), .KW(KW), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .k_len(k_len),
    .a_valid(a_valid & sel), .a_ready(ar_s), .a_data(a_data), .b_data(b_data),
    .res_valid(rv_s), .res_ready(res_ready & sel), .res_data(rd_s), .res_ovf(ro_s),
    .busy(bz_s), .done(dn_s)
  );

  assign a_ready   = sel ? ar_s : ar_u;
  assign res_valid = sel ? rv_s : rv_u;
  assign busy      = sel ? bz_s : bz_u;
  assign done      = sel ? dn_s : dn_u;
  assign res_data  = sel ? rd_s : rd_u;
  assign res_ovf   = sel ? ro_s : ro_u;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beat-by-beat reference with exact integer sums and ACC_W range checks.
  task automatic model(input int k, output exp_t e);
    longint mx, mn, acc, av, bv, s, u;
    bit o;
    mx = sel ? (64'sd1 <<< (ACC_W - 1)) - 1 : (64'sd1 <<< ACC_W) - 1;
    mn = sel ? -(64'sd1 <<< (ACC_W - 1)) : 0;
    e.c  = '0;
    e.ov = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = 0;
        o   = 1'b0;
        for (int kk = 0; kk < k; kk++) begin
          av = a_m[i][kk] & 255;
          bv = b_m[kk][j] & 255;
          if (sel && av >= 128) av -= 256;
          if (sel && bv >= 128) bv -= 256;
          s = acc + av * bv;
          if (Sat && o) continue;
          if (s > mx || s < mn) begin
            o = 1'b1;
            if (Sat) acc = (s > mx) ? mx : mn;
            else begin
              u = s & ((64'sd1 <<< ACC_W) - 1);
              if (sel && u > mx) u -= (64'sd1 <<< ACC_W);
              acc = u;
            end
          end else begin
            acc = s;
          end
        end
        e.c[(i*N+j)*ACC_W +: ACC_W] = acc[ACC_W-1:0];
        e.ov[i*N+j] = o;
      end
    end
  endtask

  // One full operation: start, K beats (optional one-cycle gaps), optional result stall with a
  // stray start, then handshake and done/idle checks.
  task automatic run_op(input int k, input bit gap, input int hold, input bit poke);
    exp_t e, got_e;
    int   cnt;
    logic [7:0] kb;
    model(k, e);
    sb.push_back(e);
    kb = k[7:0];
    @(negedge clk);
    start = 1'b1;
    k_len = kb;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    if (k == 0) begin
      check_eq("res_valid_k0_next_cycle", res_valid, 1);
    end else begin
      for (int kk = 0; kk < k; kk++) begin
        if (gap && kk > 0) begin
          a_valid = 1'b0;
          @(negedge clk);
        end
        a_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
          a_data[i*DW +: DW] = 8'(a_m[i][kk]);
          b_data[i*DW +: DW] = 8'(b_m[kk][i]);
        end
        cnt = 0;
        while (!a_ready && cnt < 20) begin
          @(negedge clk);
          cnt++;
        end
        check_eq("a_ready_in_feed", a_ready, 1);
        @(negedge clk);
      end
      a_valid = 1'b0;
      cnt = 0;
      while (!res_valid && cnt < 100) begin
        @(negedge clk);
        cnt++;
      end
      check_eq("latency_edges", cnt, 2 * N);
    end
    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start = poke && (h == 1);
      check_eq("res_valid_held", res_valid, 1);
      check_eq("res_data_stable", res_data, e.c);
      @(negedge clk);
    end
    start = 1'b0;
    if (sb.size() == 0) begin
      check_eq("scoreboard_nonempty", 0, 1);
    end else begin
      got_e = sb.pop_front();
      check_eq("res_data", res_data, got_e.c);
      check_eq("res_ovf", res_ovf, got_e.ov);
    end
    check_eq("done_before_handshake", done, 0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_eq("done_pulse", done, 1);
    check_eq("res_valid_dropped", res_valid, 0);
    @(negedge clk);
    check_eq("done_single_cycle", done, 0);
    check_eq("idle_after_op", busy, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    sel       = 1'b0;
    start     = 1'b0;
    a_valid   = 1'b0;
    res_ready = 1'b0;
    k_len     = '0;
    a_data    = '0;
    b_data    = '0;
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < 32; kk++) begin
        a_m[i][kk] = 0;
        b_m[kk][i] = 0;
      end
    @(negedge clk);
    @(negedge clk);
    check_eq("reset_res_valid", res_valid, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_a_ready", a_ready, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_res_data", res_data, 0);
    check_eq("reset_res_ovf", res_ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Beats offered while idle must be refused.
    a_valid = 1'b1;
    a_data  = 16'hffff;
    b_data  = 16'hffff;
    @(negedge clk);
    check_eq("a_ready_idle", a_ready, 0);
    a_valid = 1'b0;
    @(negedge clk);

    // Test 1: B = identity.
    a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = 4;
    b_m[0][0] = 1; b_m[0][1] = 0; b_m[1][0] = 0; b_m[1][1] = 1;
    run_op(2, 1'b0, 0, 1'b0);

    // Test 2: gapped beats.
    b_m[0][0] = 5; b_m[0][1] = 6; b_m[1][0] = 7; b_m[1][1] = 8;
    run_op(2, 1'b1, 0, 1'b0);

    // Test 3: result stall with a stray start during OUT.
    run_op(2, 1'b1, 5, 1'b1);

    // Test 4: overflow with all-ones operands.
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < 20; kk++) begin
        a_m[i][kk] = 255;
        b_m[kk][i] = 255;
      end
    run_op(20, 1'b0, 0, 1'b0);

    // Test 5: reset mid-FEED, then rerun test 2.
    @(negedge clk);
    start = 1'b1;
    k_len = 8'd3;
    @(negedge clk);
    start   = 1'b0;
    a_valid = 1'b1;
    a_data  = 16'h0403;
    b_data  = 16'h0605;
    @(negedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midreset_busy", busy, 0);
    check_eq("midreset_a_ready", a_ready, 0);
    check_eq("midreset_res_data", res_data, 0);
    check_eq("midreset_res_valid", res_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = 4;
    b_m[0][0] = 5; b_m[0][1] = 6; b_m[1][0] = 7; b_m[1][1] = 8;
    run_op(2, 1'b1, 0, 1'b0);

    // Test 6: signed instance, then an empty K.
    sel = 1'b1;
    @(negedge clk);
    a_m[0][0] = -1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = -4;
    b_m[0][0] = 5;  b_m[0][1] = -6; b_m[1][0] = 7; b_m[1][1] = 8;
    run_op(2, 1'b0, 0, 1'b0);
    run_op(0, 1'b0, 2, 1'b0);

    check_eq("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
